// File: rtl/alu3_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu3_seq_if : operand/command and result bus of the three-operand ALU |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface alu3_seq_if;
  logic       start;
  logic [2:0] func;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] c;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry;
  logic       zero;

  modport master (
    output start, func, a, b, c,
    input  busy, done, result, carry, zero
  );

  modport slave (
    input  start, func, a, b, c,
    output busy, done, result, carry, zero
  );
endinterface
`default_nettype wire

// File: rtl/alu3_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu3_seq : two-stage sequential ALU, result = (a OP b) OP c          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module alu3_seq (
  input  wire logic clk,
  input  wire logic rst,
  alu3_seq_if.slave bus
);

  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_SUB = 3'b001;
  localparam logic [2:0] FUNC_AND = 3'b010;
  localparam logic [2:0] FUNC_OR  = 3'b011;
  localparam logic [2:0] FUNC_XOR = 3'b100;
  localparam logic [2:0] FUNC_MAX = 3'b101;
  localparam logic [2:0] FUNC_MIN = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] func_q;
  logic [7:0] a_q, b_q, c_q;
  logic [8:0] t_q, t_d;
  logic [8:0] fin_d;
  logic [7:0] result_q;
  logic       carry_q;
  logic       zero_q;

  // Bit 8 carries the adder carry-out / subtractor borrow; zero for all other ops.
  function automatic logic [8:0] alu_op(input logic [2:0] f,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
    logic [8:0] r;
    r = {1'b0, x};
    case (f)
      FUNC_ADD: r = {1'b0, x} + {1'b0, y};
      FUNC_SUB: r = {1'b0, x} - {1'b0, y};
      FUNC_AND: r = {1'b0, x & y};
      FUNC_OR:  r = {1'b0, x | y};
      FUNC_XOR: r = {1'b0, x ^ y};
      FUNC_MAX: r = {1'b0, (x > y) ? x : y};
      FUNC_MIN: r = {1'b0, (x < y) ? x : y};
      default:  r = {1'b0, x};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    t_d   = alu_op(func_q, a_q, b_q);
    fin_d = alu_op(func_q, t_q[7:0], c_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_q   <= 3'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      c_q      <= 8'd0;
      t_q      <= 9'd0;
      result_q <= 8'd0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        func_q <= bus.func;
        a_q    <= bus.a;
        b_q    <= bus.b;
        c_q    <= bus.c;
      end
      if (state_q == S1) begin
        t_q <= t_d;
      end
      if (state_q == S2) begin
        result_q <= fin_d[7:0];
        carry_q  <= t_q[8] | fin_d[8];
        zero_q   <= (fin_d[7:0] == 8'h00);
      end
    end
  end

  assign bus.busy   = (state_q == S1) || (state_q == S2);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;

endmodule
`default_nettype wire

// File: doc/alu3_seq.md
ALU3_SEQ -- requirements
Module: alu3_seq

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 func  input  3  operation select; 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MAX, 110 MIN, 111 PASS.
REQ-006 a, b, c  input  8 each  operand bus driven by the upstream operand router (slots a, b, c).
REQ-007 busy  output  1  high while an operation is in progress (states S1, S2).
REQ-008 done  output  1  single-cycle completion pulse (state DONE).
REQ-009 result  output  8  registered result of the last completed operation.
REQ-010 carry  output  1  registered carry/borrow of the last completed operation.
REQ-011 zero  output  1  registered flag, high when result == 8'h00.

Function
REQ-012 FSM states SHALL be IDLE, S1, S2, DONE; transitions IDLE->S1 on start, S1->S2, S2->DONE, DONE->IDLE, all unconditional except IDLE.
REQ-013 On the edge sampling start=1 in IDLE, the block SHALL latch func, a, b, c into internal registers; later changes on the inputs SHALL NOT affect the operation.
REQ-014 S1 SHALL compute a 9-bit intermediate t = a OP b from the latched operands.
REQ-015 S2 SHALL compute the final value = t[7:0] OP c and register result, carry and zero on the S2->DONE edge.
REQ-016 Latency: start sampled at edge k -> result/carry/zero updated and done=1 after edge k+2; done falls after edge k+3.
REQ-017 ADD: result = (a+b+c) mod 256; carry = carry-out of stage 1 OR carry-out of stage 2.
REQ-018 SUB: result = (a-b-c) mod 256; carry = borrow of stage 1 OR borrow of stage 2.
REQ-019 AND/OR/XOR: bitwise over all three operands; carry = 0.
REQ-020 MAX/MIN: unsigned maximum/minimum of a, b, c; carry = 0.
REQ-021 PASS: result = latched a; carry = 0.
REQ-022 zero SHALL be computed from the final 8-bit result for every func.
REQ-023 start SHALL be ignored in S1, S2 and DONE; no queuing, no effect on latched operands.
REQ-024 result, carry, zero SHALL hold their values from the last completion until the next S2->DONE edge.
REQ-025 busy SHALL be 1 exactly in S1 and S2; done SHALL be 1 exactly in DONE; both are decoded from registered state only.

Reset
REQ-026 rst=1 SHALL force state IDLE and clear busy, done, result, carry, zero and all operand registers to 0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL abort it: no done pulse, outputs remain 0 after release.
REQ-028 After rst deasserts, the first start sampled in IDLE SHALL begin a normal operation.

Verification
REQ-029 ADD a=8'hF0 b=8'h20 c=8'h05 start pulse -> 2 edges later result=8'h15 carry=1 zero=0, done high one cycle.
REQ-030 SUB a=8'h10 b=8'h20 c=8'h01 -> result=8'hEF carry=1 zero=0.
REQ-031 MAX a=3 b=9 c=7 -> result=9; then MIN same operands -> result=3; carry=0 both.
REQ-032 AND a=8'hF0 b=8'h0F c=8'hFF -> result=8'h00 zero=1 carry=0.
REQ-033 Start ADD 1+1+1, hold start high and change a to 8'h80 during S1/S2 -> result=3, exactly one done pulse, second operation starts only after return to IDLE.
REQ-034 Start any op, assert rst in S2 -> no done, all outputs 0; after release, XOR a=8'hAA b=8'h55 c=8'hFF completes with result=8'h00 zero=1.
